// File: rtl/pentary_operand_loader.sv
// Digit-serial loader for the pentary ALU: assembles A/B operands and opcode LSD-first,
// validates digit codes, zero-pads short words, flags long ones, and hands words off via valid/ready.
module pentary_operand_loader #(
  parameter  int DIGITS = 4,
  localparam int W      = 3 * DIGITS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_a_digit,
  input  logic [2:0]   in_b_digit,
  input  logic [1:0]   in_op,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b,
  output logic [2:0]   out_op,
  output logic         out_invalid,
  output logic         out_overflow
);

  localparam int         CW   = $clog2(DIGITS + 1);
  localparam logic [2:0] ZERO = 3'b010;

  typedef enum logic {FILL, PEND} state_t;

  state_t         state, state_nx;
  logic [W-1:0]   asm_a, asm_b, word_a, word_b;
  logic [1:0]     asm_op, word_op;
  logic [CW-1:0]  count;
  logic           inv, ovf, word_inv, word_ovf;
  logic           accept, out_free, load_out;
  logic           a_legal, b_legal;

  assign in_ready = rst_n && (state == FILL);
  assign accept   = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;
  assign a_legal  = (in_a_digit <= 3'b100);
  assign b_legal  = (in_b_digit <= 3'b100);

  // Assembly contents as they will be once the current pair is merged in.
  always_comb begin
    word_a   = asm_a;
    word_b   = asm_b;
    word_op  = (count == '0) ? in_op : asm_op;
    word_inv = inv;
    word_ovf = ovf;
    if (count == CW'(DIGITS)) begin
      word_ovf = 1'b1;
    end else begin
      if (!a_legal || !b_legal) word_inv = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
        if (count == CW'(k)) begin
          word_a[3*k +: 3] = a_legal ? in_a_digit : ZERO;
          word_b[3*k +: 3] = b_legal ? in_b_digit : ZERO;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load_out = 1'b0;
    case (state)
      FILL: begin
        if (accept && in_last) begin
          if (out_free) load_out = 1'b1;
          else          state_nx = PEND;
        end
      end
      PEND: begin
        if (out_free) begin
          load_out = 1'b1;
          state_nx = FILL;
        end
      end
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_a        <= {DIGITS{ZERO}};
      out_b        <= {DIGITS{ZERO}};
      out_op       <= 3'b111;
      out_invalid  <= 1'b0;
      out_overflow <= 1'b0;
      asm_a        <= {DIGITS{ZERO}};
      asm_b        <= {DIGITS{ZERO}};
      asm_op       <= 2'b00;
      count        <= '0;
      inv          <= 1'b0;
      ovf          <= 1'b0;
    end else begin
      if (load_out) begin
        out_valid <= 1'b1;
        // FILL loads the word completing this cycle; PEND loads the parked word.
        if (state == FILL) begin
          out_a        <= word_a;
          out_b        <= word_b;
          out_op       <= {1'b0, word_op};
          out_invalid  <= word_inv;
          out_overflow <= word_ovf;
        end else begin
          out_a        <= asm_a;
          out_b        <= asm_b;
          out_op       <= {1'b0, asm_op};
          out_invalid  <= inv;
          out_overflow <= ovf;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (load_out) begin
        asm_a  <= {DIGITS{ZERO}};
        asm_b  <= {DIGITS{ZERO}};
        asm_op <= 2'b00;
        count  <= '0;
        inv    <= 1'b0;
        ovf    <= 1'b0;
      end else if (accept) begin
        asm_a  <= word_a;
        asm_b  <= word_b;
        asm_op <= word_op;
        inv    <= word_inv;
        ovf    <= word_ovf;
        if (count != CW'(DIGITS)) count <= count + CW'(1);
      end
    end
  end

endmodule
